// File: rtl/dmem_responder.sv
// Data-memory target for the MEM-stage d_m_* port: one request at a time, optional wait states, single-cycle hit.
// Build option: define DMEM_RESPONDER_WAIT_EN to compile in the WAIT state and honour WAIT_CYCLES.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [ADDR_WIDTH-1:0]   d_m_addr_i,
    input  logic                    d_m_rden_i,
    input  logic                    d_m_wren_i,
    input  logic [DATA_WIDTH/8-1:0] d_m_wmask_i,
    input  logic [DATA_WIDTH-1:0]   d_m_wdata_i,
    output logic                    d_m_hit_o,
    output logic [DATA_WIDTH-1:0]   d_m_rdata_o,
    output logic                    err_o
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

`ifdef DMEM_RESPONDER_WAIT_EN
    localparam bit         WAIT_ON   = (WAIT_CYCLES != 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
`else
    // Without the wait-state build WAIT_CYCLES has no effect.
    localparam bit         WAIT_ON   = 1'b0 && (WAIT_CYCLES != 0);
`endif

    logic [1:0]            state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg;
    logic [LANES-1:0]      mask_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  wr_reg;
    logic                  bad_reg;
    logic                  hit_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic bad;
    logic in_resp;

    // The hit cycle is a mandatory gap: the initiator still holds the finished request there.
    assign accept  = (state_reg == S_IDLE) && !hit_reg && (d_m_rden_i || d_m_wren_i);
    assign bad     = (d_m_rden_i && d_m_wren_i) || ((d_m_addr_i >> (OFF_W + IDX_W)) != '0);
    assign in_resp = (state_reg == S_RESP);

`ifdef DMEM_RESPONDER_WAIT_EN
    logic [3:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_reg <= 4'd0;
        end else if (accept) begin
            cnt_reg <= WAIT_LOAD;
        end else if (state_reg == S_WAIT) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = WAIT_ON ? S_WAIT : S_RESP;
                end
            end
`ifdef DMEM_RESPONDER_WAIT_EN
            S_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = S_RESP;
                end
            end
`endif
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= S_IDLE;
            hit_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            hit_reg   <= in_resp;
            err_reg   <= in_resp && bad_reg;
            if (in_resp && !bad_reg && !wr_reg) begin
                rdata_reg <= mem[idx_reg];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_reg   <= d_m_addr_i[OFF_W +: IDX_W];
            mask_reg  <= d_m_wmask_i;
            wdata_reg <= d_m_wdata_i;
            wr_reg    <= d_m_wren_i;
            bad_reg   <= bad;
        end
    end

    // Array has no reset so its contents survive a core reset.
    always_ff @(posedge clk_i) begin
        if (in_resp && wr_reg && !bad_reg) begin
            for (int i = 0; i < LANES; i++) begin
                if (mask_reg[i]) begin
                    mem[idx_reg][i*8 +: 8] <= wdata_reg[i*8 +: 8];
                end
            end
        end
    end

    assign d_m_hit_o   = hit_reg;
    assign err_o       = err_reg;
    assign d_m_rdata_o = rdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; expected completions go through a scoreboard queue.
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_WAIT_EN
    localparam int EXP_W = 3;
`else
    localparam int EXP_W = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] addr = '0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic        hit;
    logic [31:0] rdata;
    logic        err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [1024];
    logic [31:0] model_rdata = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;

    dmem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (1024),
        .WAIT_CYCLES(3)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .d_m_addr_i (addr),
        .d_m_rden_i (rden),
        .d_m_wren_i (wren),
        .d_m_wmask_i(wmask),
        .d_m_wdata_i(wdata),
        .d_m_hit_o  (hit),
        .d_m_rdata_o(rdata),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drives one request, updates the model, then waits for and checks its completion.
    task automatic req(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d, input bit scramble);
        logic        is_bad;
        logic [9:0]  idx;
        exp_t        e;
        exp_t        got_e;
        int          k;
        bit          got;
        is_bad = (rd && wr) || (a >= 32'd4096);
        idx    = a[11:2];
        if (!is_bad && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
            end
        end else if (!is_bad && rd) begin
            model_rdata = model[idx];
        end
        e.rdata = model_rdata;
        e.err   = is_bad;
        sb.push_back(e);
        addr = a; rden = rd; wren = wr; wmask = m; wdata = d;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            k++;
            #1;
            if (scramble) begin
                if (k <= EXP_W) begin
                    addr  = $urandom;
                    wdata = $urandom;
                    wmask = 4'($urandom_range(0, 15));
                    rden  = 1'($urandom_range(0, 1));
                    wren  = 1'($urandom_range(0, 1));
                end else begin
                    addr = a; rden = rd; wren = wr; wmask = m; wdata = d;
                end
            end
            @(negedge clk);
            if (hit === 1'b1) got = 1'b1;
        end
        check({tag, "_hit_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(EXP_W + 2));
        got_e = sb.pop_front();
        check({tag, "_err"}, 32'(err), 32'(got_e.err));
        check({tag, "_rdata"}, rdata, got_e.rdata);
        n_txn++;
        $display("txn %0d %s rd=%0b wr=%0b addr=%h mask=%b wdata=%h -> rdata=%h err=%0b lat=%0d",
                 n_txn, tag, rd, wr, a, m, d, rdata, err, k);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 32'(hit), 32'd0);
        rden = 1'b0; wren = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_no_hit", 32'(hit), 32'd0);
        end
    endtask

    initial begin
        #1;
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        req("wr_full",   1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
        req("rd_full",   1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b0);

        req("preload",   1'b0, 1'b1, 32'h20, 4'b1111, 32'h11223344, 1'b0);
        req("wr_mask",   1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0);
        req("rd_mask",   1'b1, 1'b0, 32'h20, 4'b0000, 32'h0, 1'b0);

        req("rd_wait",   1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b1);

        req("ill_both",  1'b1, 1'b1, 32'h10, 4'b1111, 32'h0, 1'b0);
        req("rd_after_both", 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b0);
        req("ill_rd_oor", 1'b1, 1'b0, 32'd4096, 4'b0000, 32'h0, 1'b0);
        req("ill_wr_oor", 1'b0, 1'b1, 32'd4096 + 32'h20, 4'b1111, 32'h0, 1'b0);
        req("rd_after_oor", 1'b1, 1'b0, 32'h20, 4'b0000, 32'h0, 1'b0);

        req("wr_mask0",  1'b0, 1'b1, 32'h20, 4'b0000, 32'h55555555, 1'b0);
        req("rd_offset", 1'b1, 1'b0, 32'h23, 4'b0000, 32'h0, 1'b0);

        req("b2b_wr1",   1'b0, 1'b1, 32'h30, 4'b1111, 32'h11111111, 1'b0);
        req("b2b_wr2",   1'b0, 1'b1, 32'h30, 4'b0011, 32'h22222222, 1'b0);
        req("b2b_rd",    1'b1, 1'b0, 32'h30, 4'b0000, 32'h0, 1'b0);
        idle_check(5);

        // Request dropped by reset: it must neither write nor complete.
        addr = 32'h10; rden = 1'b0; wren = 1'b1; wmask = 4'b1111; wdata = 32'h0;
        @(posedge clk);
        if (EXP_W > 0) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_hit", 32'(hit), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        wren = 1'b0;
        model_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle_check(2);
        @(posedge clk);
        #1;
        req("rd_after_rst", 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
